cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer with halt and program-load modes.
// Optional single-step hold in the IDLE phase is enabled by defining SEQ_STEP_EN.
module cpu_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       Load,
  input  logic       step,
  input  logic [2:0] Opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic       load_busy,
  output logic [2:0] phase
);

  typedef enum logic [3:0] {
    S_INST_ADDR,
    S_INST_FETCH,
    S_INST_LOAD,
    S_IDLE,
    S_OP_ADDR,
    S_OP_FETCH,
    S_ALU_OP,
    S_STORE,
    S_HALTED,
    S_LOADING
  } state_e;

  typedef enum logic [2:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
  } opcode_e;

  state_e state_q, state_d;
  logic   run_q;

  logic   aluop, is_sto, is_jmp, is_skz, is_hlt;

  assign aluop  = (Opcode == OP_ADD) || (Opcode == OP_AND) ||
                  (Opcode == OP_XOR) || (Opcode == OP_LDA);
  assign is_sto = (Opcode == OP_STO);
  assign is_jmp = (Opcode == OP_JMP);
  assign is_skz = (Opcode == OP_SKZ);
  assign is_hlt = (Opcode == OP_HLT);

`ifndef SEQ_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  always_comb begin
    state_d = state_q;
    if (Load) begin
      state_d = S_LOADING;
    end else begin
      case (state_q)
        S_INST_ADDR:  state_d = S_INST_FETCH;
        S_INST_FETCH: state_d = S_INST_LOAD;
        S_INST_LOAD:  state_d = S_IDLE;
`ifdef SEQ_STEP_EN
        S_IDLE:       state_d = step ? S_OP_ADDR : S_IDLE;
`else
        S_IDLE:       state_d = S_OP_ADDR;
`endif
        S_OP_ADDR:    state_d = is_hlt ? S_HALTED : S_OP_FETCH;
        S_OP_FETCH:   state_d = S_ALU_OP;
        S_ALU_OP:     state_d = S_STORE;
        S_STORE:      state_d = S_INST_ADDR;
        S_HALTED:     state_d = S_HALTED;
        S_LOADING:    state_d = S_INST_ADDR;
        default:      state_d = S_INST_ADDR;
      endcase
    end
  end

  // run_q delays the first advance by one edge so reset release is synchronised.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_INST_ADDR;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) state_q <= state_d;
    end
  end

  always_comb begin
    sel       = 1'b0;
    rd        = 1'b0;
    ld_ir     = 1'b0;
    inc_pc    = 1'b0;
    ld_pc     = 1'b0;
    ld_ac     = 1'b0;
    wr        = 1'b0;
    data_e    = 1'b0;
    halt      = 1'b0;
    load_busy = 1'b0;
    phase     = 3'd0;
    case (state_q)
      S_INST_ADDR: begin
        phase = 3'd0;
        sel   = 1'b1;
      end
      S_INST_FETCH: begin
        phase = 3'd1;
        sel   = 1'b1;
        rd    = 1'b1;
      end
      S_INST_LOAD: begin
        phase = 3'd2;
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_IDLE: begin
        phase = 3'd3;
        sel   = 1'b1;
        rd    = 1'b1;
      end
      S_OP_ADDR: begin
        phase  = 3'd4;
        inc_pc = 1'b1;
      end
      S_OP_FETCH: begin
        phase = 3'd5;
        rd    = aluop;
      end
      S_ALU_OP: begin
        phase  = 3'd6;
        rd     = aluop;
        inc_pc = is_skz & zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      S_STORE: begin
        phase  = 3'd7;
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
      S_HALTED: begin
        phase = 3'd4;
        halt  = 1'b1;
      end
      S_LOADING: begin
        phase     = 3'd0;
        load_busy = 1'b1;
      end
      default: phase = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: hand-computed per-phase output vectors.
// Output vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, load_busy}.
module tb_cpu_sequencer;

  logic       clock, reset, Load, step, zero;
  logic [2:0] Opcode;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, load_busy;
  logic [2:0] phase;
  logic [9:0] obs;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  cpu_sequencer dut (
    .clock(clock), .reset(reset), .Load(Load), .step(step),
    .Opcode(Opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt),
    .load_busy(load_busy), .phase(phase)
  );

  assign obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, load_busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, STO = 3'd6, JMP = 3'd7;

  localparam logic [9:0] V_P0   = 10'b1000000000;
  localparam logic [9:0] V_P1   = 10'b1100000000;
  localparam logic [9:0] V_P2   = 10'b1110000000;
  localparam logic [9:0] V_P4   = 10'b0001000000;
  localparam logic [9:0] V_HALT = 10'b0000000010;
  localparam logic [9:0] V_LOAD = 10'b0000000001;
  localparam logic [9:0] V_ZERO = 10'b0000000000;

  localparam logic [79:0] T_ADD = {V_P0, V_P1, V_P2, V_P1, V_P4,
                                   10'b0100000000, 10'b0100000000, 10'b0100010000};
  localparam logic [79:0] T_STO = {V_P0, V_P1, V_P2, V_P1, V_P4,
                                   V_ZERO, 10'b0000000100, 10'b0000001100};
  localparam logic [79:0] T_SKZ1 = {V_P0, V_P1, V_P2, V_P1, V_P4,
                                    V_ZERO, 10'b0001000000, V_ZERO};
  localparam logic [79:0] T_SKZ0 = {V_P0, V_P1, V_P2, V_P1, V_P4,
                                    V_ZERO, V_ZERO, V_ZERO};
  localparam logic [79:0] T_JMP = {V_P0, V_P1, V_P2, V_P1, V_P4,
                                   V_ZERO, 10'b0000100000, 10'b0000100000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks phases 0..nph-1 starting at a negedge where the DUT sits in P0.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [79:0] tbl, input int unsigned nph);
    Opcode = op;
    zero   = z;
    for (int unsigned i = 0; i < nph; i++) begin
      chk($sformatf("%s_phase%0d", tag, i), 32'(phase), i);
      chk($sformatf("%s_out%0d", tag, i), 32'(obs), 32'(tbl[(7-i)*10 +: 10]));
      chk($sformatf("%s_rdwr%0d", tag, i), 32'(rd & wr), 0);
      @(negedge clock);
    end
  endtask

  initial begin
    reset  = 1'b1;
    Load   = 1'b0;
    step   = 1'b0;
    zero   = 1'b0;
    Opcode = ADD;
    #2 reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("rst_phase", 32'(phase), 0);
      chk("rst_out", 32'(obs), 32'(V_P0));
    end
    reset = 1'b1;
    @(negedge clock);
    chk("sync_hold_phase", 32'(phase), 0);
    chk("sync_hold_out", 32'(obs), 32'(V_P0));
    @(negedge clock);
    chk("sync_p1", 32'(phase), 1);
    repeat (7) @(negedge clock);
    chk("wrap_p0", 32'(phase), 0);

    run_instr("add_a", ADD, 1'b0, T_ADD, 8);
    run_instr("add_b", ADD, 1'b0, T_ADD, 8);
    run_instr("sto",   STO, 1'b0, T_STO, 8);
    run_instr("skz1",  SKZ, 1'b1, T_SKZ1, 8);
    run_instr("skz0",  SKZ, 1'b0, T_SKZ0, 8);
    run_instr("jmp",   JMP, 1'b0, T_JMP, 8);

    run_instr("hlt", HLT, 1'b0, T_ADD, 5);
    for (int unsigned i = 0; i < 20; i++) begin
      chk("halt_phase", 32'(phase), 4);
      chk("halt_out", 32'(obs), 32'(V_HALT));
      @(negedge clock);
    end
    Load = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("hload_out", 32'(obs), 32'(V_LOAD));
      chk("hload_phase", 32'(phase), 0);
    end
    Load = 1'b0;
    @(negedge clock);
    chk("hload_exit_phase", 32'(phase), 0);
    chk("hload_exit_out", 32'(obs), 32'(V_P0));

    run_instr("abort", STO, 1'b0, T_STO, 6);
    chk("abort_p6_out", 32'(obs), 32'(10'b0000000100));
    Load = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("abort_out", 32'(obs), 32'(V_LOAD));
      chk("abort_wr", 32'(wr), 0);
    end
    Load = 1'b0;
    @(negedge clock);
    chk("abort_exit_phase", 32'(phase), 0);

    run_instr("step", ADD, 1'b0, T_ADD, 3);
`ifdef SEQ_STEP_EN
    for (int unsigned i = 0; i < 10; i++) begin
      chk("step_hold", 32'(phase), 3);
      @(negedge clock);
    end
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    chk("step_adv", 32'(phase), 4);
`else
    chk("nostep_p3", 32'(phase), 3);
    @(negedge clock);
    chk("nostep_adv", 32'(phase), 4);
`endif
    repeat (4) @(negedge clock);
    chk("step_wrap", 32'(phase), 0);

    run_instr("mrst", STO, 1'b0, T_STO, 6);
    reset = 1'b0;
    #1;
    chk("mrst_phase", 32'(phase), 0);
    chk("mrst_out", 32'(obs), 32'(V_P0));
    repeat (2) begin
      @(negedge clock);
      chk("mrst_wr", 32'(wr), 0);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_sync", 32'(phase), 0);
    @(negedge clock);
    chk("mrst_p1", 32'(phase), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
